// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE bundle, data-SRAM response, WB handshake and ID forwarding around the memory stage.
interface mem_stage_if #(parameter int EXCEP_W = 86);
    logic               EXE_signal_valid;
    logic [76:0]        EXE_signal;
    logic [EXCEP_W-1:0] EXE_excep;
    logic               EXE_excep_hit;
    logic               EXE_readygo;
    logic               MEM_allowin;
    logic               data_sram_data_ok;
    logic [31:0]        data_sram_rdata;
    logic               WB_allowin;
    logic               MEM_flush;
    logic               WB_signal_valid;
    logic [69:0]        WB_signal;
    logic [EXCEP_W-1:0] MEM_excep;
    logic               MEM_to_EXE_excep;
    logic               mem_fwd_we;
    logic [4:0]         mem_fwd_waddr;
    logic [31:0]        mem_fwd_data;
    logic               mem_ld_busy;

    modport master (
        output EXE_signal_valid, EXE_signal, EXE_excep, EXE_excep_hit, EXE_readygo,
        output data_sram_data_ok, data_sram_rdata, WB_allowin, MEM_flush,
        input  MEM_allowin, WB_signal_valid, WB_signal, MEM_excep, MEM_to_EXE_excep,
        input  mem_fwd_we, mem_fwd_waddr, mem_fwd_data, mem_ld_busy
    );

    modport slave (
        input  EXE_signal_valid, EXE_signal, EXE_excep, EXE_excep_hit, EXE_readygo,
        input  data_sram_data_ok, data_sram_rdata, WB_allowin, MEM_flush,
        output MEM_allowin, WB_signal_valid, WB_signal, MEM_excep, MEM_to_EXE_excep,
        output mem_fwd_we, mem_fwd_waddr, mem_fwd_data, mem_ld_busy
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: waits for the data-SRAM response, aligns/extends load data and hands the result to WB.
module mem_stage #(
    parameter int EXCEP_W  = 86,
    parameter int CANCEL_W = 2
) (
    input logic        clk,
    input logic        resetn,
    mem_stage_if.slave bus
);
    logic               valid_q, valid_d;
    logic [75:0]        sig_q, sig_d;
    logic [EXCEP_W-1:0] excep_q, excep_d;
    logic               hit_q, hit_d;
    logic               outst_q, outst_d;
    logic               buf_valid_q, buf_valid_d;
    logic [31:0]        buf_q, buf_d;
    logic [CANCEL_W-1:0] cancel_q, cancel_d, cancel_dec;

    logic [31:0] exe_result, pc, rdata, ld_data, final_result;
    logic [4:0]  rf_waddr;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic rf_we, res_from_mem, ld_b, ld_bu, ld_h, ld_hu, ld_w;
    logic stale, resp, ready_go, accept, wait_st, cancel_inc;

    assign exe_result   = sig_q[31:0];
    assign rf_waddr     = sig_q[36:32];
    assign rf_we        = sig_q[37];
    assign res_from_mem = sig_q[38];
    assign pc           = sig_q[70:39];
    assign ld_w         = sig_q[71];
    assign ld_hu        = sig_q[72];
    assign ld_h         = sig_q[73];
    assign ld_bu        = sig_q[74];
    assign ld_b         = sig_q[75];

    // responses owed to flushed requests are swallowed before the live one is recognised
    assign stale    = bus.data_sram_data_ok & (cancel_q != '0);
    assign resp     = bus.data_sram_data_ok & (cancel_q == '0);
    assign ready_go = !outst_q | buf_valid_q | resp;
    assign wait_st  = valid_q & outst_q & !buf_valid_q;
    assign accept   = bus.EXE_readygo & bus.MEM_allowin & !bus.MEM_flush;

    assign off          = exe_result[1:0];
    assign rdata        = buf_valid_q ? buf_q : bus.data_sram_rdata;
    assign ld_byte      = rdata[{off, 3'b000} +: 8];
    assign ld_half      = off[1] ? rdata[31:16] : rdata[15:0];
    assign ld_data      = ld_b  ? {{24{ld_byte[7]}}, ld_byte} :
                          ld_bu ? {24'd0, ld_byte} :
                          ld_h  ? {{16{ld_half[15]}}, ld_half} :
                          ld_hu ? {16'd0, ld_half} :
                          ld_w  ? rdata : 32'd0;
    assign final_result = res_from_mem ? ld_data : exe_result;

    assign cancel_inc = bus.MEM_flush & wait_st & !resp;
    assign cancel_dec = cancel_q - CANCEL_W'(stale);
    assign cancel_d   = cancel_inc ? ((&cancel_dec) ? cancel_dec : cancel_dec + CANCEL_W'(1)) : cancel_dec;

    always_comb begin
        valid_d     = valid_q;
        sig_d       = sig_q;
        excep_d     = excep_q;
        hit_d       = hit_q;
        outst_d     = outst_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (bus.MEM_flush) begin
            valid_d     = 1'b0;
            outst_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = bus.EXE_signal_valid;
            sig_d       = bus.EXE_signal[75:0];
            excep_d     = bus.EXE_excep;
            hit_d       = bus.EXE_excep_hit;
            outst_d     = bus.EXE_signal_valid & bus.EXE_signal[76];
            buf_valid_d = 1'b0;
        end else if (valid_q & ready_go & bus.WB_allowin) begin
            valid_d     = 1'b0;
            outst_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else if (wait_st & resp) begin
            buf_valid_d = 1'b1;
            buf_d       = bus.data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q     <= 1'b0;
            sig_q       <= '0;
            excep_q     <= '0;
            hit_q       <= 1'b0;
            outst_q     <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            cancel_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            sig_q       <= sig_d;
            excep_q     <= excep_d;
            hit_q       <= hit_d;
            outst_q     <= outst_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            cancel_q    <= cancel_d;
        end
    end

    assign bus.MEM_allowin      = !valid_q | (ready_go & bus.WB_allowin);
    assign bus.WB_signal_valid  = valid_q & ready_go & !bus.MEM_flush;
    assign bus.WB_signal        = {pc, rf_we, rf_waddr, final_result};
    assign bus.MEM_excep        = excep_q;
    assign bus.MEM_to_EXE_excep = valid_q & hit_q;
    assign bus.mem_fwd_we       = valid_q & rf_we;
    assign bus.mem_fwd_waddr    = rf_waddr;
    assign bus.mem_fwd_data     = final_result;
    assign bus.mem_ld_busy      = valid_q & res_from_mem & !ready_go;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized stimulus for mem_stage, checked every cycle against a
// transaction-level model (one slot, in-order SRAM responses tagged with their owning instruction).
module tb_mem_stage;
    localparam int EXCEP_W = 86;

    logic clk = 1'b0;
    logic resetn;

    mem_stage_if #(.EXCEP_W(EXCEP_W)) bus ();
    mem_stage #(.EXCEP_W(EXCEP_W), .CANCEL_W(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        logic [31:0] rd;
        int          due;
    } resp_t;

    resp_t sq[$];
    int n_vec = 0, n_err = 0, cyc = 0, next_id = 1, last_due = 0;
    bit armed = 0;
    bit s_full = 0, s_got = 0, s_hit = 0;
    int s_id = 0;
    logic [76:0]        s_sig;
    logic [69:0]        s_wb;
    logic [EXCEP_W-1:0] s_excep;
    bit          f_rd_en = 0;
    logic [31:0] f_rd = '0;
    int          f_dly = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind: 0 alu, 1 store, 2 ld_b, 3 ld_bu, 4 ld_h, 5 ld_hu, 6 ld_w
    function automatic logic [76:0] mk(input int kind, input logic [31:0] res, input logic [4:0] wa, input logic [31:0] pc);
        logic [4:0] ld;
        ld = kind >= 2 ? 5'b10000 >> (kind - 2) : 5'b00000;
        return {kind >= 1, ld, pc, kind >= 2, kind != 1, wa, res};
    endfunction

    function automatic logic [31:0] load_val(input logic [76:0] s, input logic [31:0] rd);
        int off = int'(s[1:0]);
        int b = int'((rd >> (8 * off)) & 32'hFF);
        int h = int'((rd >> (16 * (off / 2))) & 32'hFFFF);
        if (s[75]) return b >= 128 ? 32'(b - 256) : 32'(b);
        if (s[74]) return 32'(b);
        if (s[73]) return h >= 32768 ? 32'(h - 65536) : 32'(h);
        if (s[72]) return 32'(h);
        return rd;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (sq[i]) if (!(s_full && sq[i].owner == s_id)) n++;
        return n;
    endfunction

    // SRAM: responses in request order, each no earlier than its due cycle
    initial begin
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0 && sq[0].due <= cyc) begin
                bus.data_sram_data_ok = 1'b1;
                bus.data_sram_rdata = sq[0].rd;
            end else begin
                bus.data_sram_data_ok = 1'b0;
                bus.data_sram_rdata = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        bit dok, hit_now, ready, exp_allow, flush, acc;
        logic [31:0] rd;
        resp_t e;
        dok = bus.data_sram_data_ok === 1'b1;
        hit_now = dok && sq.size() > 0 && s_full && sq[0].owner == s_id;
        ready = s_full && (!s_sig[76] || s_got || hit_now);
        exp_allow = !s_full || (ready && bus.WB_allowin);
        flush = bus.MEM_flush;
        if (armed) begin
            check("wb_valid", bus.WB_signal_valid, ready && !flush);
            check("allowin", bus.MEM_allowin, exp_allow);
            check("ld_busy", bus.mem_ld_busy, s_full && s_sig[38] && !ready);
            check("fwd_we", bus.mem_fwd_we, s_full && s_sig[37]);
            check("to_exe_excep", bus.MEM_to_EXE_excep, s_full && s_hit);
            if (s_full) begin
                check("excep", bus.MEM_excep, s_excep);
                check("fwd_waddr", bus.mem_fwd_waddr, s_sig[36:32]);
                if (ready) begin
                    check("wb_signal", bus.WB_signal, s_wb);
                    check("fwd_data", bus.mem_fwd_data, s_wb[31:0]);
                end
            end
        end
        if (!resetn) begin
            s_full = 0;
            s_got = 0;
            sq.delete();
            last_due = 0;
            armed = 1;
        end else begin
            if (dok && sq.size() > 0) begin
                if (hit_now) s_got = 1;
                void'(sq.pop_front());
            end
            acc = bus.EXE_readygo && exp_allow && !flush;
            if (flush || (s_full && ready && bus.WB_allowin)) s_full = 0;
            if (acc) begin
                s_full = bus.EXE_signal_valid;
                if (s_full) begin
                    s_id = next_id++;
                    s_sig = bus.EXE_signal;
                    s_excep = bus.EXE_excep;
                    s_hit = bus.EXE_excep_hit;
                    s_got = 0;
                    rd = f_rd_en ? f_rd : $urandom;
                    if (s_sig[76]) begin
                        e.owner = s_id;
                        e.rd = rd;
                        e.due = cyc + 1 + (f_dly >= 0 ? f_dly : int'($urandom_range(0, 3)));
                        if (e.due <= last_due) e.due = last_due + 1;
                        last_due = e.due;
                        sq.push_back(e);
                    end
                    s_wb = {s_sig[70:39], s_sig[37], s_sig[36:32], s_sig[38] ? load_val(s_sig, rd) : s_sig[31:0]};
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [76:0] s, input logic hit);
        bit acc = 0;
        bus.EXE_signal = s;
        bus.EXE_signal_valid = 1'b1;
        bus.EXE_readygo = 1'b1;
        bus.EXE_excep_hit = hit;
        bus.EXE_excep = EXCEP_W'({$urandom, $urandom, $urandom});
        for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge clk);
            acc = bus.MEM_allowin && !bus.MEM_flush;
            tick();
        end
        check("offer_timeout", acc, 1);
        bus.EXE_signal_valid = 1'b0;
        bus.EXE_readygo = 1'b0;
    endtask

    task automatic wait_wb(output logic [31:0] res, output int busy);
        bit got = 0;
        busy = 0;
        res = '0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_ld_busy) busy++;
            if (bus.WB_signal_valid && bus.WB_allowin) begin
                got = 1;
                res = bus.WB_signal[31:0];
            end
            tick();
        end
        check("wb_timeout", got, 1);
    endtask

    logic [31:0] res;
    int busy;

    initial begin
        resetn = 1'b0;
        bus.EXE_signal_valid = 1'b0;
        bus.EXE_signal = '0;
        bus.EXE_excep = '0;
        bus.EXE_excep_hit = 1'b0;
        bus.EXE_readygo = 1'b0;
        bus.WB_allowin = 1'b1;
        bus.MEM_flush = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        f_rd_en = 1;
        f_rd = 32'h80AABBCC;
        f_dly = 2;
        offer(mk(2, 32'h1003, 5'd3, 32'h1c000000), 1'b0);
        wait_wb(res, busy);
        check("ldb_busy_cycles", busy, 2);
        check("ldb_result", res, 32'hFFFFFF80);
        @(negedge clk);
        check("wb_pulse", bus.WB_signal_valid, 0);
        tick();

        f_rd = 32'h92345678; f_dly = 1;
        offer(mk(5, 32'h2002, 5'd4, 32'h1c000004), 1'b0);
        wait_wb(res, busy);
        check("ldhu_result", res, 32'h00009234);
        f_rd = 32'h00008001;
        offer(mk(4, 32'h2000, 5'd5, 32'h1c000008), 1'b0);
        wait_wb(res, busy);
        check("ldh_result", res, 32'hFFFF8001);
        f_rd = 32'h92345678;
        offer(mk(6, 32'h2004, 5'd6, 32'h1c00000c), 1'b0);
        wait_wb(res, busy);
        check("ldw_result", res, 32'h92345678);

        f_rd = 32'hCAFEF00D; f_dly = 1;
        bus.WB_allowin = 1'b0;
        offer(mk(6, 32'h3000, 5'd7, 32'h1c000010), 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("stall_allowin", bus.MEM_allowin, 0);
            tick();
        end
        bus.WB_allowin = 1'b1;
        wait_wb(res, busy);
        check("buffered_result", res, 32'hCAFEF00D);

        f_rd = 32'hDEAD0000; f_dly = 3;
        offer(mk(6, 32'h4000, 5'd8, 32'h1c000014), 1'b0);
        tick();
        bus.MEM_flush = 1'b1;
        tick();
        bus.MEM_flush = 1'b0;
        f_rd = 32'h12345678; f_dly = 0;
        offer(mk(6, 32'h4004, 5'd9, 32'h1c000018), 1'b0);
        wait_wb(res, busy);
        check("post_flush_result", res, 32'h12345678);

        f_rd_en = 0; f_dly = -1;
        bus.EXE_readygo = 1'b1;
        bus.EXE_signal_valid = 1'b1;
        bus.EXE_excep_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.EXE_signal = mk(0, 32'h55 + 32'(i), 5'(i + 1), 32'h1c000100 + 32'(4 * i));
            @(negedge clk);
            if (i > 0) begin
                check("alu_wb_valid", bus.WB_signal_valid, 1);
                check("alu_fwd_data", bus.mem_fwd_data, 32'h55 + 32'(i - 1));
                check("alu_busy", bus.mem_ld_busy, 0);
            end
            tick();
        end
        bus.EXE_signal_valid = 1'b0;
        bus.EXE_readygo = 1'b0;
        tick();

        bus.WB_allowin = 1'b0;
        offer(mk(0, 32'h77, 5'd10, 32'h1c000200), 1'b1);
        @(negedge clk);
        check("excep_hit_out", bus.MEM_to_EXE_excep, 1);
        tick();
        bus.WB_allowin = 1'b1;
        repeat (2) tick();

        f_rd_en = 1; f_rd = 32'h11111111; f_dly = 8;
        offer(mk(6, 32'h5000, 5'd11, 32'h1c000300), 1'b0);
        tick();
        bus.MEM_flush = 1'b1;
        tick();
        bus.MEM_flush = 1'b0;
        f_rd = 32'h22222222; f_dly = 3;
        offer(mk(6, 32'h5004, 5'd12, 32'h1c000304), 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_wb_valid", bus.WB_signal_valid, 0);
        check("rst_busy", bus.mem_ld_busy, 0);
        check("rst_fwd_we", bus.mem_fwd_we, 0);
        check("rst_to_exe", bus.MEM_to_EXE_excep, 0);
        tick();
        f_rd = 32'hA5A55A5A; f_dly = 1;
        offer(mk(6, 32'h6000, 5'd13, 32'h1c000400), 1'b0);
        wait_wb(res, busy);
        check("post_reset_result", res, 32'hA5A55A5A);

        f_rd_en = 0; f_dly = -1;
        for (int n = 0; n < 1500; n++) begin
            bus.WB_allowin = $urandom_range(0, 3) != 0;
            bus.MEM_flush = ($urandom_range(0, 19) == 0) && stale_cnt() < 2;
            bus.EXE_readygo = $urandom_range(0, 4) != 0;
            bus.EXE_signal_valid = $urandom_range(0, 6) != 0;
            bus.EXE_signal = mk(int'($urandom_range(0, 6)), $urandom, 5'($urandom), $urandom);
            bus.EXE_excep_hit = $urandom_range(0, 9) == 0;
            bus.EXE_excep = EXCEP_W'({$urandom, $urandom, $urandom});
            tick();
        end
        bus.MEM_flush = 1'b0;
        bus.EXE_readygo = 1'b0;
        bus.EXE_signal_valid = 1'b0;
        bus.WB_allowin = 1'b1;
        repeat (15) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; consumes the 77-bit EXE->MEM bundle plus the exception bundle.
- Waits for the data-SRAM response (data_ok) of a request the execute stage already launched.
- Aligns and sign/zero-extends load data, then hands a 70-bit result bundle to writeback.
- Tracks outstanding requests and discards responses belonging to flushed instructions.

Parameters:
EXCEP_W, 86, width of exception/CSR bundle carried EXE->MEM->WB unmodified
CANCEL_W, 2, width of discard counter for responses of flushed requests

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
EXE_signal_valid  in  1  EXE bundle valid (already gated by EXE flush)
EXE_signal  in  77  {mem_req, ld_b, ld_bu, ld_h, ld_hu, ld_w, pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], exe_result[31:0]}
EXE_excep  in  EXCEP_W  exception/CSR bundle, passed through
EXE_excep_hit  in  1  bundle carries exception or ertn
EXE_readygo  in  1  EXE can advance this cycle
MEM_allowin  out  1  MEM can accept a bundle
data_sram_data_ok  in  1  SRAM response strobe
data_sram_rdata  in  32  SRAM read data
WB_allowin  in  1  WB can accept
MEM_flush  in  1  exception/ertn commit in WB; kill MEM content
WB_signal_valid  out  1  bundle valid to WB
WB_signal  out  70  {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
MEM_excep  out  EXCEP_W  registered exception bundle
MEM_to_EXE_excep  out  1  valid & latched excep_hit (blocks EXE stores)
mem_fwd_we  out  1  valid & rf_we, for ID bypass
mem_fwd_waddr  out  5  destination register
mem_fwd_data  out  32  final_result
mem_ld_busy  out  1  valid & res_from_mem & !ready_go (ID must stall)

Behaviour:
- Reset (resetn=0 at posedge): valid=0, bundle and excep registers=0, outstanding=0, buf_valid=0, cancel_cnt=0. WB_signal_valid=0, MEM_to_EXE_excep=0, mem_fwd_we=0, mem_ld_busy=0.
- Accept: on posedge with EXE_readygo & MEM_allowin & !MEM_flush, latch EXE_signal/EXE_excep/EXE_excep_hit; valid<=EXE_signal_valid. outstanding<=EXE_signal_valid & mem_req; buf_valid<=0.
- States per slot: EMPTY (valid=0); WAIT (valid, outstanding, !buf_valid); DONE (valid, and either !outstanding or buf_valid).
- ready_go = !outstanding | buf_valid | (data_ok & cancel_cnt==0).
- MEM_allowin = !valid | (ready_go & WB_allowin).
- WB_signal_valid = valid & ready_go & !MEM_flush.
- Response handling:
  - A data_ok with cancel_cnt!=0 is a stale response: cancel_cnt decrements, the response is dropped, and the current slot is not completed.
  - Otherwise, a data_ok while in WAIT captures rdata into the buffer (buf_valid<=1) if WB_allowin=0. If WB_allowin=1 the bundle passes the same cycle from the live rdata.
  - data_ok is never earlier than the cycle after acceptance.
- Load extraction, offset = exe_result[1:0]:
  - ld_w: word as is.
  - ld_b/ld_bu: byte at offset, sign-/zero-extended.
  - ld_h/ld_hu: halfword at offset[1] (offset 0 -> bits 15:0, offset 2 -> bits 31:16), sign-/zero-extended.
  - final_result = res_from_mem ? extracted : exe_result.
  - Stores complete on data_ok; rdata is ignored.
- Flush: MEM_flush=1 at posedge sets valid<=0. If the slot was in WAIT and data_ok did not arrive that cycle, cancel_cnt increments (saturating at 2^CANCEL_W-1). Flush in the same cycle as an EXE advance takes priority: nothing is accepted.
- Exception bundles still complete via data_ok if mem_req=1 (EXE issued the request). MEM_excep is passed through unaltered.
- Simultaneous data_ok and new acceptance: allowed only when ready_go. The response belongs to the departing bundle.
- Reset mid-WAIT clears cancel_cnt. SRAM is reset in the same domain, so no stale responses follow reset.

Test Plan:
- ld_b at exe_result=0x1003, rdata=0x80AABBCC, data_ok 2 cycles after acceptance -> mem_ld_busy=1 for 2 cycles; then WB_signal final_result=0xFFFFFF80, WB_signal_valid pulses 1 cycle.
- ld_hu at offset 2, rdata=0x9234_5678 -> 0x00009234; ld_h at offset 0, rdata=0x0000_8001 -> 0xFFFF8001; ld_w -> 0x92345678.
- Load, data_ok arrives while WB_allowin=0 for 3 cycles, rdata changes after data_ok -> buffered value delivered when WB_allowin rises; MEM_allowin=0 throughout the stall.
- Load in WAIT, MEM_flush pulse -> valid=0, cancel_cnt=1. Next load accepted; first data_ok (rdata=0xDEAD0000) dropped, second (0x12345678) delivered as final_result.
- ALU op (mem_req=0, exe_result=0x55) with WB_allowin=1 -> passes in 1 cycle. mem_fwd_we=1, mem_fwd_data=0x55, mem_ld_busy=0. Back-to-back bundles every cycle with no bubble.
- Bundle with EXE_excep_hit=1 -> MEM_to_EXE_excep=1 while valid. Pull resetn low mid-WAIT -> all outputs 0 next edge, cancel_cnt=0.
